// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and data bundle for serial_subtractor.
//   start  : request to begin a subtraction (master -> slave)
//   A, B   : minuend / subtrahend, WIDTH bits (master -> slave)
//   busy   : operation in progress (slave -> master)
//   done   : one-cycle result-valid pulse (slave -> master)
//   Diff   : (A - B) mod 2^WIDTH (slave -> master)
//   Borrow : A < B unsigned (slave -> master)
//   Ovf    : signed overflow, present only when SERIAL_SUBTRACTOR_OVF_EN
//            is defined (slave -> master)
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             Ovf;

    modport master (output start, A, B, input busy, done, Diff, Borrow, Ovf);
    modport slave  (input start, A, B, output busy, done, Diff, Borrow, Ovf);
`else
    modport master (output start, A, B, input busy, done, Diff, Borrow);
    modport slave  (input start, A, B, output busy, done, Diff, Borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: one full-subtractor cell processes one bit
// per clock, LSB first, over WIDTH cycles (IDLE -> SHIFT x WIDTH -> DONE).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (start, A, B in; busy, done, Diff,
//           Borrow, optional Ovf out)
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the Ovf output
// (signed two's-complement overflow of A - B).
// All outputs are registered; done is high in the cycle after the edge that
// leaves DONE, i.e. WIDTH+1 edges after the accepting edge.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             a_lsb, b_lsb, d_bit, br_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out of a_q/b_q, so keep copies for Ovf.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        // Full-subtractor cell on the current LSBs.
        a_lsb   = a_q[0];
        b_lsb   = b_q[0];
        d_bit   = a_lsb ^ b_lsb ^ br_q;
        br_next = (~a_lsb & b_lsb) | (~(a_lsb ^ b_lsb) & br_q);

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // Goes high one edge after reset release; start is ignored until then.
        ready_d  = 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start && ready_q) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    a_msb_d = bus.A[WIDTH-1];
                    b_msb_d = bus.B[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                // After WIDTH shifts the first difference bit lands in bit 0.
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                diff_d   = res_q;
                borrow_d = br_q;
                busy_d   = 1'b0;
                state_d  = IDLE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                ovf_d    = (a_msb_q ^ b_msb_q) & (res_q[WIDTH-1] ^ a_msb_q);
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.Ovf    = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, a request to begin a subtraction, sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits, the minuend, sampled on an accepted start.
REQ-006 SHALL have port B, input, WIDTH bits, the subtrahend, sampled on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit, high while an operation is in SHIFT or DONE.
REQ-008 SHALL have port done, output, 1 bit, a single-cycle pulse marking a valid result.
REQ-009 SHALL have port Diff, output, WIDTH bits, the result (A - B) mod 2^WIDTH.
REQ-010 SHALL have port Borrow, output, 1 bit, high when A < B unsigned.

Function
REQ-011 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-012 SHALL, in IDLE with start=1, latch A and B into shift registers, clear the borrow flop and the bit counter, and enter SHIFT on the next edge.
REQ-013 SHALL, on each SHIFT cycle, process the LSBs a, b and the borrow flop br as d = a^b^br and br_next = (~a&b) | (~(a^b)&br).
REQ-014 SHALL, on each SHIFT cycle, shift both operands right and shift d into the result register from the MSB side.
REQ-015 SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles, with the counter counting 0..WIDTH-1.
REQ-016 SHALL, in DONE, drive done=1 for exactly one cycle, update Diff and Borrow from the result register and the final br, and return to IDLE.
REQ-017 SHALL have a latency such that, with start accepted at edge N, done is high in the cycle after edge N+WIDTH+1.
REQ-018 SHALL drive busy=1 in SHIFT and DONE and busy=0 in IDLE.
REQ-019 SHALL ignore start while busy=1; A and B changes during an operation SHALL NOT affect the result.
REQ-020 SHALL accept start=1 in the first IDLE cycle after DONE, giving back-to-back operations one idle cycle apart.
REQ-021 SHALL hold Diff and Borrow stable between done pulses; they change only in the DONE cycle.
REQ-022 SHALL produce Diff=0 and Borrow=0 for A=B, and Diff=1 and Borrow=1 for A=0, B=all-ones.

Reset
REQ-023 SHALL, when rst_n is low, immediately force state=IDLE, busy=0, done=0, Diff=0, Borrow=0, and clear the counter, borrow flop and shift registers.
REQ-024 SHALL, on a reset asserted mid-operation, abort the operation with no done pulse; after release, the block SHALL wait for a new start.
REQ-025 SHALL require one full clock of rst_n high before start is honoured.

Configuration
REQ-026 SHALL support the macro SERIAL_SUBTRACTOR_OVF_EN.
REQ-027 SHALL, when SERIAL_SUBTRACTOR_OVF_EN is defined, add output Ovf, 1 bit, meaning signed two's-complement overflow (sign(A) != sign(B) and sign(Diff) != sign(A)).
REQ-028 SHALL update Ovf in the DONE cycle only, hold it between done pulses, and reset it to 0.
REQ-029 SHALL, when SERIAL_SUBTRACTOR_OVF_EN is undefined, omit the Ovf port and logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover exhaustive 1-bit cell check: with WIDTH=2, all 16 A/B pairs -> Diff = (A-B) mod 4, Borrow = (A<B).
REQ-031 SHALL cover WIDTH=8, A=0x05, B=0x03 -> done exactly 10 cycles after the start edge, Diff=0x02, Borrow=0.
REQ-032 SHALL cover WIDTH=8, A=0x00, B=0x01 -> Diff=0xFF, Borrow=1; with the OVF macro, A=0x80, B=0x01 -> Diff=0x7F, Ovf=1.
REQ-033 SHALL cover start pulsed again mid-SHIFT with new A and B -> ignored, first result unchanged, only one done pulse.
REQ-034 SHALL cover rst_n low at SHIFT cycle 3 -> outputs 0 at once, no done, and the next start=1 with A=0x10, B=0x10 -> Diff=0x00, Borrow=0.
REQ-035 SHALL cover 1000 random back-to-back operations at WIDTH=16 -> every result matches a reference model, and done count equals start-accept count.
